// File: rtl/memcpy_pkg.sv
// Shared types for the word-granular memcpy/memmove engine.
package memcpy_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      FIN
   } state_t;

   typedef enum logic {
      FWD,
      BWD
   } dir_t;

   localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/memcpy_engine.sv
// Memory-to-memory word copy engine with memmove semantics.
// Reads via port 1, writes via port 2, one word per two cycles.
module memcpy_engine
   import memcpy_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [31:0]      src,
   input  logic [31:0]      dst,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [31:0]      mem_a1,
   input  logic [31:0]      mem_rd1,
   output logic             mem_we1,
   output logic [31:0]      mem_a2,
   output logic [31:0]      mem_wd2,
   output logic             mem_we2
);

   state_t           state;
   state_t           state_n;
   dir_t             dir;
   dir_t             dir_in;
   logic [31:0]      cur_src;
   logic [31:0]      cur_dst;
   logic [31:0]      data_q;
   logic [LEN_W-1:0] remaining;
   logic             err_q;

   logic [31:0] len_w;
   logic [31:0] span;
   logic [31:0] last_off;
   logic        misalign;

   // Copy backward only when dst lands inside the source range,
   // so no source word is overwritten before it is read.
   assign len_w    = 32'(len);
   assign span     = src + (len_w << 2);
   assign last_off = (len_w - 32'd1) << 2;
   assign misalign = (src[1:0] != 2'b00) || (dst[1:0] != 2'b00);
   assign dir_in   = ((dst > src) && (dst < span)) ? BWD : FWD;

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (misalign || (len == '0))
                  state_n = FIN;
               else
                  state_n = READ;
            end
         end
         READ:  state_n = WRITE;
         WRITE: begin
            if (remaining > LEN_W'(1))
               state_n = READ;
            else
               state_n = FIN;
         end
         FIN:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         dir       <= FWD;
         cur_src   <= '0;
         cur_dst   <= '0;
         data_q    <= '0;
         remaining <= '0;
         err_q     <= 1'b0;
      end else begin
         state <= state_n;
         unique case (state)
            IDLE: begin
               if (start) begin
                  dir       <= dir_in;
                  remaining <= len;
                  err_q     <= misalign;
                  if (dir_in == BWD) begin
                     cur_src <= src + last_off;
                     cur_dst <= dst + last_off;
                  end else begin
                     cur_src <= src;
                     cur_dst <= dst;
                  end
               end
            end
            READ: data_q <= mem_rd1;
            WRITE: begin
               remaining <= remaining - LEN_W'(1);
               if (dir == BWD) begin
                  cur_src <= cur_src - WORD_BYTES;
                  cur_dst <= cur_dst - WORD_BYTES;
               end else begin
                  cur_src <= cur_src + WORD_BYTES;
                  cur_dst <= cur_dst + WORD_BYTES;
               end
            end
            FIN: ;
            default: ;
         endcase
      end
   end

   // Write enable is pure state decode so it drops the moment reset hits.
   assign mem_we2 = (state == WRITE);
   assign mem_we1 = 1'b0;
   assign mem_a1  = cur_src;
   assign mem_a2  = cur_dst;
   assign mem_wd2 = data_q;
   assign busy    = (state != IDLE);
   assign done    = (state == FIN);
   assign err     = done & err_q;

endmodule

// File: tb/tb_memcpy_engine.sv
// Scoreboard bench for memcpy_engine against a behavioural RAM.
module tb_memcpy_engine;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] src = '0;
   logic [31:0] dst = '0;
   logic [15:0] len = '0;
   logic        busy, done, err;
   logic [31:0] mem_a1, mem_rd1, mem_a2, mem_wd2;
   logic        mem_we1, mem_we2;

   logic [31:0] ram [64];
   logic        pl_we = 1'b0;
   logic [5:0]  pl_idx = '0;
   logic [31:0] pl_dat = '0;

   typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
   typedef struct { int cyc; logic e; } dn_t;
   wr_t wq[$];
   dn_t dq[$];
   wr_t w;
   dn_t dn;

   int errors = 0;
   int checks = 0;
   int wcount = 0;
   int cyc = 0;
   int e;
   int wc0;

   memcpy_engine #(.LEN_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .src(src), .dst(dst), .len(len),
      .busy(busy), .done(done), .err(err),
      .mem_a1(mem_a1), .mem_rd1(mem_rd1), .mem_we1(mem_we1),
      .mem_a2(mem_a2), .mem_wd2(mem_wd2), .mem_we2(mem_we2)
   );

   always #5 clk = ~clk;

   assign mem_rd1 = ram[mem_a1[7:2]];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we2)
         ram[mem_a2[7:2]] <= mem_wd2;
      else if (pl_we)
         ram[pl_idx] <= pl_dat;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (mem_we2) begin
            wcount++;
            if (wq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write: got a=%h d=%h want none",
                        mem_a2, mem_wd2);
            end else begin
               w = wq.pop_front();
               chk("wr_addr", mem_a2, w.a);
               chk("wr_data", mem_wd2, w.d);
            end
         end
         if (done) begin
            if (dq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done: got done=1 want 0");
            end else begin
               dn = dq.pop_front();
               chk("done_cycle", cyc, dn.cyc);
               chk("done_err", {31'd0, err}, {31'd0, dn.e});
            end
         end
      end
   end

   task automatic poke(input int i, input logic [31:0] d);
      @(negedge clk);
      pl_we = 1'b1;
      pl_idx = i[5:0];
      pl_dat = d;
      @(posedge clk);
      #1 pl_we = 1'b0;
   endtask

   task automatic clear_ram();
      for (int i = 0; i < 64; i++) poke(i, 32'd0);
   endtask

   task automatic pushw(input logic [31:0] a, input logic [31:0] d);
      wq.push_back('{a: a, d: d});
   endtask

   task automatic go(input logic [31:0] s, input logic [31:0] d,
                     input logic [15:0] l, input int n,
                     input logic experr, input bit expect_done,
                     output int ecyc);
      @(negedge clk);
      src = s; dst = d; len = l; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      ecyc = cyc;
      if (expect_done) dq.push_back('{cyc: ecyc + 2 * n, e: experr});
   endtask

   task automatic wait_idle(input int bound);
      int k;
      k = 0;
      while (busy && k < bound) begin
         @(negedge clk);
         k++;
      end
      if (busy) begin
         checks++; errors++;
         $display("FAIL timeout: got busy=1 want 0 after %0d cycles", bound);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_ram();
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_we2", {31'd0, mem_we2}, 32'd0);
      chk("rst_we1", {31'd0, mem_we1}, 32'd0);
      chk("rst_a1", mem_a1, 32'd0);
      chk("rst_a2", mem_a2, 32'd0);
      chk("rst_wd2", mem_wd2, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // forward, disjoint
      poke(0, 32'h11); poke(1, 32'h22); poke(2, 32'h33); poke(3, 32'h44);
      pushw(32'h40, 32'h11); pushw(32'h44, 32'h22);
      pushw(32'h48, 32'h33); pushw(32'h4C, 32'h44);
      wc0 = wcount;
      go(32'h0, 32'h40, 16'd4, 4, 1'b0, 1'b1, e);
      wait_idle(20);
      chk("fwd_pulses", wcount - wc0, 32'd4);
      chk("fwd_ram16", ram[16], 32'h11);
      chk("fwd_ram17", ram[17], 32'h22);
      chk("fwd_ram18", ram[18], 32'h33);
      chk("fwd_ram19", ram[19], 32'h44);
      chk("fwd_mem_we1", {31'd0, mem_we1}, 32'd0);

      // overlap, backward
      poke(0, 32'd1); poke(1, 32'd2); poke(2, 32'd3); poke(3, 32'd4);
      poke(4, 32'd0);
      pushw(32'h10, 32'd4); pushw(32'h0C, 32'd3);
      pushw(32'h08, 32'd2); pushw(32'h04, 32'd1);
      go(32'h0, 32'h4, 16'd4, 4, 1'b0, 1'b1, e);
      wait_idle(20);
      chk("bwd_ram0", ram[0], 32'd1);
      chk("bwd_ram1", ram[1], 32'd1);
      chk("bwd_ram2", ram[2], 32'd2);
      chk("bwd_ram3", ram[3], 32'd3);
      chk("bwd_ram4", ram[4], 32'd4);

      // overlap, forward
      poke(1, 32'd5); poke(2, 32'd6); poke(3, 32'd7); poke(4, 32'd8);
      pushw(32'h00, 32'd5); pushw(32'h04, 32'd6);
      pushw(32'h08, 32'd7); pushw(32'h0C, 32'd8);
      go(32'h4, 32'h0, 16'd4, 4, 1'b0, 1'b1, e);
      wait_idle(20);
      chk("ofwd_ram0", ram[0], 32'd5);
      chk("ofwd_ram1", ram[1], 32'd6);
      chk("ofwd_ram2", ram[2], 32'd7);
      chk("ofwd_ram3", ram[3], 32'd8);

      // degenerate: len=0, then misaligned source
      wc0 = wcount;
      go(32'h0, 32'h40, 16'd0, 0, 1'b0, 1'b1, e);
      wait_idle(5);
      go(32'h2, 32'h40, 16'd4, 0, 1'b1, 1'b1, e);
      wait_idle(5);
      chk("degen_pulses", wcount - wc0, 32'd0);
      chk("mis_ram16", ram[16], 32'h11);
      chk("mis_ram19", ram[19], 32'h44);

      // start while busy must be ignored
      poke(32, 32'hA1); poke(33, 32'hA2);
      pushw(32'hC0, 32'hA1); pushw(32'hC4, 32'hA2);
      wc0 = wcount;
      go(32'h80, 32'hC0, 16'd2, 2, 1'b0, 1'b1, e);
      @(negedge clk);
      src = 32'h0; dst = 32'h40; len = 16'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(20);
      repeat (4) @(negedge clk);
      chk("busy_start_pulses", wcount - wc0, 32'd2);
      chk("busy_start_ram48", ram[48], 32'hA1);
      chk("busy_start_ram49", ram[49], 32'hA2);
      chk("busy_start_ram16", ram[16], 32'h11);

      // abort during the third write
      for (int i = 56; i < 60; i++) poke(i, 32'd0);
      poke(40, 32'hB0); poke(41, 32'hB1); poke(42, 32'hB2); poke(43, 32'hB3);
      pushw(32'hE0, 32'hB0); pushw(32'hE4, 32'hB1);
      go(32'hA0, 32'hE0, 16'd4, 4, 1'b0, 1'b0, e);
      repeat (5) @(posedge clk);
      #1;
      chk("abort_we2_pre", {31'd0, mem_we2}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("abort_we2", {31'd0, mem_we2}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_done", {31'd0, done}, 32'd0);
      end
      reset_n = 1'b1;
      @(negedge clk);
      chk("abort_done_after", {31'd0, done}, 32'd0);
      chk("abort_ram56", ram[56], 32'hB0);
      chk("abort_ram57", ram[57], 32'hB1);
      chk("abort_ram58", ram[58], 32'd0);
      chk("abort_ram59", ram[59], 32'd0);
      chk("abort_wq_empty", wq.size(), 32'd0);

      pushw(32'hE0, 32'hB0); pushw(32'hE4, 32'hB1);
      pushw(32'hE8, 32'hB2); pushw(32'hEC, 32'hB3);
      go(32'hA0, 32'hE0, 16'd4, 4, 1'b0, 1'b1, e);
      wait_idle(20);
      chk("redo_ram58", ram[58], 32'hB2);
      chk("redo_ram59", ram[59], 32'hB3);

      repeat (3) @(negedge clk);
      chk("end_wq_empty", wq.size(), 32'd0);
      chk("end_dq_empty", dq.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
